// File: rtl/trap_ctrl_if.sv
// Signal bundle between the commit/CSR side and the trap controller.
// The controller attaches through the slave modport; the driving side uses master.
interface trap_ctrl_if #(
    parameter int DATA_W = 64
);
    logic              io_in_mtip;
    logic              io_in_msip;
    logic [DATA_W-1:0] io_in_csr_mstatus;
    logic [DATA_W-1:0] io_in_csr_mie;
    logic [DATA_W-1:0] io_in_csr_mtvec;
    logic [DATA_W-1:0] io_in_csr_mepc;
    logic              io_in_exc_valid;
    logic [4:0]        io_in_exc_code;
    logic [DATA_W-1:0] io_in_exc_pc;
    logic              io_in_mret;
    logic              io_in_commit;
    logic [DATA_W-1:0] io_in_commit_next_pc;
    logic              io_in_pipe_empty;
    logic              io_out_stall;
    logic              io_out_flush;
    logic              io_out_redirect_valid;
    logic [DATA_W-1:0] io_out_redirect_pc;
    logic              io_out_time_irq;
    logic              io_out_soft_irq;
    logic              io_out_is_exception;
    logic [4:0]        io_out_exception;
    logic [DATA_W-1:0] io_out_pc;
    logic [DATA_W-1:0] io_out_next_pc;
    logic              io_out_mstatus_wen;
    logic [DATA_W-1:0] io_out_mstatus_wdata;

    modport slave (
        input  io_in_mtip, io_in_msip, io_in_csr_mstatus, io_in_csr_mie,
               io_in_csr_mtvec, io_in_csr_mepc, io_in_exc_valid, io_in_exc_code,
               io_in_exc_pc, io_in_mret, io_in_commit, io_in_commit_next_pc,
               io_in_pipe_empty,
        output io_out_stall, io_out_flush, io_out_redirect_valid, io_out_redirect_pc,
               io_out_time_irq, io_out_soft_irq, io_out_is_exception, io_out_exception,
               io_out_pc, io_out_next_pc, io_out_mstatus_wen, io_out_mstatus_wdata
    );

    modport master (
        output io_in_mtip, io_in_msip, io_in_csr_mstatus, io_in_csr_mie,
               io_in_csr_mtvec, io_in_csr_mepc, io_in_exc_valid, io_in_exc_code,
               io_in_exc_pc, io_in_mret, io_in_commit, io_in_commit_next_pc,
               io_in_pipe_empty,
        input  io_out_stall, io_out_flush, io_out_redirect_valid, io_out_redirect_pc,
               io_out_time_irq, io_out_soft_irq, io_out_is_exception, io_out_exception,
               io_out_pc, io_out_next_pc, io_out_mstatus_wen, io_out_mstatus_wdata
    );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: takes exceptions, drains the backend before
// interrupts, and issues one-cycle trap / mret redirect pulses to fetch and CSRs.
module trap_ctrl (
    input  logic       clock,
    input  logic       reset,
    trap_ctrl_if.slave io
);
    localparam int DATA_W = 64;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_TRAP, S_MRET} state_e;
    typedef enum logic [1:0] {K_EXC, K_SW, K_TM} kind_e;

    state_e            state_q, state_d;
    kind_e             kind_q;
    logic [4:0]        code_q;
    logic [DATA_W-1:0] exc_pc_q;
    logic [DATA_W-1:0] next_pc_q;

    logic irq_sw, irq_tm, irq_any;
    logic unused_mie;

    // Vectored mode only offsets interrupts; exceptions always land on the base.
    function automatic logic [DATA_W-1:0] trap_target(input logic [DATA_W-1:0] mtvec,
                                                      input kind_e kind);
        logic [DATA_W-1:0] base;
        base = {mtvec[DATA_W-1:2], 2'b00};
        if (mtvec[1:0] == 2'b01 && kind == K_SW) return base + 64'd12;
        if (mtvec[1:0] == 2'b01 && kind == K_TM) return base + 64'd28;
        return base;
    endfunction

    function automatic logic [DATA_W-1:0] mret_mstatus(input logic [DATA_W-1:0] m);
        logic [DATA_W-1:0] w;
        w        = m;
        w[3]     = m[7];
        w[7]     = 1'b1;
        w[12:11] = 2'b11;
        return w;
    endfunction

    assign irq_sw     = io.io_in_msip & io.io_in_csr_mie[3] & io.io_in_csr_mstatus[3];
    assign irq_tm     = io.io_in_mtip & io.io_in_csr_mie[7] & io.io_in_csr_mstatus[3];
    assign irq_any    = irq_sw | irq_tm;
    assign unused_mie = ^{io.io_in_csr_mie[DATA_W-1:8], io.io_in_csr_mie[6:4],
                          io.io_in_csr_mie[2:0]};

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (io.io_in_exc_valid) state_d = S_TRAP;
                else if (io.io_in_mret) state_d = S_MRET;
                else if (irq_any)       state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (io.io_in_exc_valid)       state_d = S_TRAP;
                else if (!irq_any)            state_d = S_IDLE;
                else if (io.io_in_pipe_empty) state_d = S_TRAP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Trap context: cause kind, exception code/pc and the interrupt return pc.
    always_ff @(posedge clock) begin
        if (reset) begin
            kind_q    <= K_EXC;
            code_q    <= '0;
            exc_pc_q  <= '0;
            next_pc_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (io.io_in_exc_valid) begin
                        kind_q   <= K_EXC;
                        code_q   <= io.io_in_exc_code;
                        exc_pc_q <= io.io_in_exc_pc;
                    end else if (!io.io_in_mret && irq_any && io.io_in_commit) begin
                        next_pc_q <= io.io_in_commit_next_pc;
                    end
                end
                S_DRAIN: begin
                    if (io.io_in_commit) next_pc_q <= io.io_in_commit_next_pc;
                    if (io.io_in_exc_valid) begin
                        kind_q   <= K_EXC;
                        code_q   <= io.io_in_exc_code;
                        exc_pc_q <= io.io_in_exc_pc;
                    end else if (irq_any && io.io_in_pipe_empty) begin
                        kind_q <= irq_sw ? K_SW : K_TM;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io.io_out_exception = code_q;
    assign io.io_out_pc        = exc_pc_q;
    assign io.io_out_next_pc   = next_pc_q;

    always_comb begin
        io.io_out_stall          = 1'b0;
        io.io_out_flush          = 1'b0;
        io.io_out_redirect_valid = 1'b0;
        io.io_out_redirect_pc    = '0;
        io.io_out_time_irq       = 1'b0;
        io.io_out_soft_irq       = 1'b0;
        io.io_out_is_exception   = 1'b0;
        io.io_out_mstatus_wen    = 1'b0;
        io.io_out_mstatus_wdata  = '0;
        case (state_q)
            S_DRAIN: io.io_out_stall = 1'b1;
            S_TRAP: begin
                io.io_out_stall          = 1'b1;
                io.io_out_flush          = 1'b1;
                io.io_out_redirect_valid = 1'b1;
                io.io_out_redirect_pc    = trap_target(io.io_in_csr_mtvec, kind_q);
                io.io_out_is_exception   = (kind_q == K_EXC);
                io.io_out_soft_irq       = (kind_q == K_SW);
                io.io_out_time_irq       = (kind_q == K_TM);
            end
            S_MRET: begin
                io.io_out_stall          = 1'b1;
                io.io_out_flush          = 1'b1;
                io.io_out_redirect_valid = 1'b1;
                io.io_out_redirect_pc    = io.io_in_csr_mepc;
                io.io_out_mstatus_wen    = 1'b1;
                io.io_out_mstatus_wdata  = mret_mstatus(io.io_in_csr_mstatus);
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed vector table, hand-written multi-cycle cases,
// and a randomized run against a behavioural model of the trap rules.
module tb_trap_ctrl;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    trap_ctrl_if bus ();
    trap_ctrl dut (.clock(clock), .reset(reset), .io(bus));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [63:0] mstatus, mie, mtvec, mepc;
        logic        mtip, msip, exc;
        logic [4:0]  code;
        logic [63:0] epc;
        logic        mret, commit;
        logic [63:0] cnp;
        int          empty_at;
        logic        pulse;
        int          stalls;
        logic        t_irq, s_irq, is_exc;
        logic [4:0]  exc_o;
        logic [63:0] pc_o, npc_o, rpc;
        logic        wen;
        logic [63:0] wdata;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.io_in_mtip = 0; bus.io_in_msip = 0;
        bus.io_in_csr_mstatus = 0; bus.io_in_csr_mie = 0;
        bus.io_in_csr_mtvec = 0; bus.io_in_csr_mepc = 0;
        bus.io_in_exc_valid = 0; bus.io_in_exc_code = 0; bus.io_in_exc_pc = 0;
        bus.io_in_mret = 0; bus.io_in_commit = 0; bus.io_in_commit_next_pc = 0;
        bus.io_in_pipe_empty = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        idle_inputs();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic chk_zero(input string p);
        chk({p, ".stall"},    bus.io_out_stall, 0);
        chk({p, ".flush"},    bus.io_out_flush, 0);
        chk({p, ".rvalid"},   bus.io_out_redirect_valid, 0);
        chk({p, ".rpc"},      bus.io_out_redirect_pc, 0);
        chk({p, ".time_irq"}, bus.io_out_time_irq, 0);
        chk({p, ".soft_irq"}, bus.io_out_soft_irq, 0);
        chk({p, ".is_exc"},   bus.io_out_is_exception, 0);
        chk({p, ".exc"},      bus.io_out_exception, 0);
        chk({p, ".pc"},       bus.io_out_pc, 0);
        chk({p, ".next_pc"},  bus.io_out_next_pc, 0);
        chk({p, ".wen"},      bus.io_out_mstatus_wen, 0);
        chk({p, ".wdata"},    bus.io_out_mstatus_wdata, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int stalls = 0;
        bit seen = 0;
        do_reset();
        bus.io_in_csr_mstatus = v.mstatus; bus.io_in_csr_mie = v.mie;
        bus.io_in_csr_mtvec = v.mtvec; bus.io_in_csr_mepc = v.mepc;
        bus.io_in_mtip = v.mtip; bus.io_in_msip = v.msip;
        bus.io_in_exc_valid = v.exc; bus.io_in_exc_code = v.code; bus.io_in_exc_pc = v.epc;
        bus.io_in_mret = v.mret; bus.io_in_commit = v.commit; bus.io_in_commit_next_pc = v.cnp;
        for (int k = 1; k <= 12 && !seen; k++) begin
            @(negedge clock);
            if (bus.io_out_stall) stalls++;
            if (bus.io_out_redirect_valid) begin
                seen = 1;
                chk({v.name, ".flush"},    bus.io_out_flush, 1);
                chk({v.name, ".time_irq"}, bus.io_out_time_irq, v.t_irq);
                chk({v.name, ".soft_irq"}, bus.io_out_soft_irq, v.s_irq);
                chk({v.name, ".is_exc"},   bus.io_out_is_exception, v.is_exc);
                chk({v.name, ".exc"},      bus.io_out_exception, v.exc_o);
                chk({v.name, ".pc"},       bus.io_out_pc, v.pc_o);
                chk({v.name, ".next_pc"},  bus.io_out_next_pc, v.npc_o);
                chk({v.name, ".rpc"},      bus.io_out_redirect_pc, v.rpc);
                chk({v.name, ".wen"},      bus.io_out_mstatus_wen, v.wen);
                chk({v.name, ".wdata"},    bus.io_out_mstatus_wdata, v.wdata);
            end
            bus.io_in_exc_valid = 0; bus.io_in_mret = 0; bus.io_in_commit = 0;
            if (k == v.empty_at) bus.io_in_pipe_empty = 1;
        end
        chk({v.name, ".pulse"},  seen, v.pulse);
        chk({v.name, ".stalls"}, stalls, stalls == v.stalls ? stalls : v.stalls);
        idle_inputs();
    endtask

    // Behavioural reference: what is pending, what kind of trap, captured context.
    bit          m_drain, m_trap, m_mret;
    int          m_kind;   // 0 exception, 1 software irq, 2 timer irq
    logic [4:0]  m_code;
    logic [63:0] m_pc, m_npc;

    function automatic logic [63:0] ref_target(input logic [63:0] mtvec, input int kind);
        logic [63:0] t;
        t = mtvec - (mtvec % 4);
        if (mtvec % 4 == 1 && kind == 1) t = t + 4 * 3;
        if (mtvec % 4 == 1 && kind == 2) t = t + 4 * 7;
        return t;
    endfunction

    function automatic logic [63:0] ref_mret(input logic [63:0] ms);
        return (ms & ~64'h1888) | 64'h1880 | (((ms >> 7) & 64'h1) << 3);
    endfunction

    task automatic model_step();
        bit sw, tm;
        sw = bus.io_in_msip && bus.io_in_csr_mie[3] && bus.io_in_csr_mstatus[3];
        tm = bus.io_in_mtip && bus.io_in_csr_mie[7] && bus.io_in_csr_mstatus[3];
        if (reset) begin
            m_drain = 0; m_trap = 0; m_mret = 0; m_kind = 0;
            m_code = 0; m_pc = 0; m_npc = 0;
        end else if (m_trap || m_mret) begin
            m_trap = 0; m_mret = 0;
        end else if (m_drain) begin
            if (bus.io_in_commit) m_npc = bus.io_in_commit_next_pc;
            if (bus.io_in_exc_valid) begin
                m_kind = 0; m_code = bus.io_in_exc_code; m_pc = bus.io_in_exc_pc;
                m_trap = 1; m_drain = 0;
            end else if (!(sw || tm)) begin
                m_drain = 0;
            end else if (bus.io_in_pipe_empty) begin
                m_kind = sw ? 1 : 2; m_trap = 1; m_drain = 0;
            end
        end else if (bus.io_in_exc_valid) begin
            m_kind = 0; m_code = bus.io_in_exc_code; m_pc = bus.io_in_exc_pc; m_trap = 1;
        end else if (bus.io_in_mret) begin
            m_mret = 1;
        end else if (sw || tm) begin
            if (bus.io_in_commit) m_npc = bus.io_in_commit_next_pc;
            m_drain = 1;
        end
    endtask

    task automatic model_check();
        logic [63:0] rpc;
        rpc = m_mret ? bus.io_in_csr_mepc :
              m_trap ? ref_target(bus.io_in_csr_mtvec, m_kind) : 64'h0;
        chk("rnd.stall",    bus.io_out_stall, m_drain || m_trap || m_mret);
        chk("rnd.flush",    bus.io_out_flush, m_trap || m_mret);
        chk("rnd.rvalid",   bus.io_out_redirect_valid, m_trap || m_mret);
        chk("rnd.rpc",      bus.io_out_redirect_pc, rpc);
        chk("rnd.is_exc",   bus.io_out_is_exception, m_trap && m_kind == 0);
        chk("rnd.soft_irq", bus.io_out_soft_irq, m_trap && m_kind == 1);
        chk("rnd.time_irq", bus.io_out_time_irq, m_trap && m_kind == 2);
        chk("rnd.exc",      bus.io_out_exception, m_code);
        chk("rnd.pc",       bus.io_out_pc, m_pc);
        chk("rnd.next_pc",  bus.io_out_next_pc, m_npc);
        chk("rnd.wen",      bus.io_out_mstatus_wen, m_mret);
        chk("rnd.wdata",    bus.io_out_mstatus_wdata,
            m_mret ? ref_mret(bus.io_in_csr_mstatus) : 64'h0);
    endtask

    task automatic rand_inputs();
        reset = ($urandom_range(0, 99) < 3);
        if ($urandom_range(0, 9) == 0) begin
            bus.io_in_csr_mstatus    = {$urandom, $urandom};
            bus.io_in_csr_mstatus[3] = ($urandom_range(0, 9) < 7);
            bus.io_in_csr_mie        = {$urandom, $urandom};
            bus.io_in_csr_mtvec      = {$urandom, $urandom};
            bus.io_in_csr_mepc       = {$urandom, $urandom};
        end
        bus.io_in_mtip           = ($urandom_range(0, 2) == 0);
        bus.io_in_msip           = ($urandom_range(0, 3) == 0);
        bus.io_in_exc_valid      = ($urandom_range(0, 99) < 8);
        bus.io_in_exc_code       = 5'($urandom);
        bus.io_in_exc_pc         = {$urandom, $urandom};
        bus.io_in_mret           = ($urandom_range(0, 99) < 8);
        bus.io_in_commit         = $urandom_range(0, 1) == 1;
        bus.io_in_commit_next_pc = {$urandom, $urandom};
        bus.io_in_pipe_empty     = ($urandom_range(0, 99) < 35);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        //        name         mstatus  mie    mtvec                  mepc     mtip msip exc code   epc      mret cmt cnp                    empty | pulse stalls t s e exc_o  pc_o     npc_o                  rpc                    wen wdata
        vecs[0]  = '{"tm_irq",    64'h8,  64'h80, 64'h8000_0000,         64'h0,    1, 0, 0, 5'h0,  64'h0,    0, 1, 64'h100,               2,  1, 3, 1, 0, 0, 5'h0,  64'h0,    64'h100,               64'h8000_0000,         0, 64'h0};
        vecs[1]  = '{"sw_vec",    64'h8,  64'h88, 64'h8000_0001,         64'h0,    1, 1, 0, 5'h0,  64'h0,    0, 1, 64'h100,               2,  1, 3, 0, 1, 0, 5'h0,  64'h0,    64'h100,               64'h8000_000C,         0, 64'h0};
        vecs[2]  = '{"exc",       64'h0,  64'h0,  64'h400,               64'h0,    0, 0, 1, 5'h2,  64'h2000, 0, 0, 64'h0,                 0,  1, 1, 0, 0, 1, 5'h2,  64'h2000, 64'h0,                 64'h400,               0, 64'h0};
        vecs[3]  = '{"mret",      64'h80, 64'h0,  64'h0,                 64'h3000, 0, 0, 0, 5'h0,  64'h0,    1, 0, 64'h0,                 0,  1, 1, 0, 0, 0, 5'h0,  64'h0,    64'h0,                 64'h3000,              1, 64'h1888};
        vecs[4]  = '{"tm_vec",    64'h8,  64'h80, 64'h1001,              64'h0,    1, 0, 0, 5'h0,  64'h0,    0, 0, 64'h0,                 1,  1, 2, 1, 0, 0, 5'h0,  64'h0,    64'h0,                 64'h101C,              0, 64'h0};
        vecs[5]  = '{"exc_vec",   64'h0,  64'h0,  64'h4001,              64'h0,    0, 0, 1, 5'h5,  64'hAAA0, 0, 0, 64'h0,                 0,  1, 1, 0, 0, 1, 5'h5,  64'hAAA0, 64'h0,                 64'h4000,              0, 64'h0};
        vecs[6]  = '{"wrap",      64'h8,  64'h80, 64'hFFFF_FFFF_FFFF_FFF5, 64'h0,  1, 0, 0, 5'h0,  64'h0,    0, 1, 64'hDEAD_BEEF_0000_0004, 1, 1, 2, 1, 0, 0, 5'h0,  64'h0,    64'hDEAD_BEEF_0000_0004, 64'h10,              0, 64'h0};
        vecs[7]  = '{"prio_exc",  64'h8,  64'h88, 64'h100,               64'h3000, 1, 1, 1, 5'h1F, 64'h1234, 1, 1, 64'h500,               0,  1, 1, 0, 0, 1, 5'h1F, 64'h1234, 64'h0,                 64'h100,               0, 64'h0};
        vecs[8]  = '{"prio_mret", 64'h8,  64'h80, 64'h100,               64'h4444, 1, 0, 0, 5'h0,  64'h0,    1, 0, 64'h0,                 0,  1, 1, 0, 0, 0, 5'h0,  64'h0,    64'h0,                 64'h4444,              1, 64'h1880};
        vecs[9]  = '{"rsvd_mode", 64'h8,  64'h80, 64'h2002,              64'h0,    1, 0, 0, 5'h0,  64'h0,    0, 0, 64'h0,                 1,  1, 2, 1, 0, 0, 5'h0,  64'h0,    64'h0,                 64'h2000,              0, 64'h0};
        vecs[10] = '{"masked",    64'h0,  64'h88, 64'h100,               64'h0,    1, 1, 0, 5'h0,  64'h0,    0, 0, 64'h0,                 1,  0, 0, 0, 0, 0, 5'h0,  64'h0,    64'h0,                 64'h0,                 0, 64'h0};
        vecs[11] = '{"sw_only",   64'h8,  64'h8,  64'h300,               64'h0,    1, 1, 0, 5'h0,  64'h0,    0, 1, 64'h77,                3,  1, 4, 0, 1, 0, 5'h0,  64'h0,    64'h77,                64'h300,               0, 64'h0};

        do_reset();
        chk_zero("reset_state");

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // Latched context must clear on reset.
        run_vec(vecs[2]);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk_zero("reset_clears");

        // Interrupt disabled while draining: back to idle, no pulse.
        do_reset();
        bus.io_in_csr_mstatus = 64'h8; bus.io_in_csr_mie = 64'h80; bus.io_in_mtip = 1;
        bus.io_in_commit = 1; bus.io_in_commit_next_pc = 64'h40;
        @(negedge clock);
        chk("mask.drain_stall", bus.io_out_stall, 1);
        bus.io_in_commit = 0; bus.io_in_csr_mie = 64'h0; bus.io_in_pipe_empty = 1;
        @(negedge clock);
        chk("mask.stall_drop", bus.io_out_stall, 0);
        chk("mask.next_pc", bus.io_out_next_pc, 64'h40);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("mask.no_irq", {bus.io_out_time_irq, bus.io_out_redirect_valid}, 0);
        end

        // Exception arriving while draining wins over the interrupt.
        do_reset();
        bus.io_in_csr_mstatus = 64'h8; bus.io_in_csr_mie = 64'h80; bus.io_in_mtip = 1;
        bus.io_in_csr_mtvec = 64'h8001;
        @(negedge clock);
        chk("dexc.drain_stall", bus.io_out_stall, 1);
        bus.io_in_exc_valid = 1; bus.io_in_exc_code = 5'd7; bus.io_in_exc_pc = 64'h5550;
        @(negedge clock);
        bus.io_in_exc_valid = 0;
        chk("dexc.is_exc", bus.io_out_is_exception, 1);
        chk("dexc.time_irq", bus.io_out_time_irq, 0);
        chk("dexc.exc", bus.io_out_exception, 5'd7);
        chk("dexc.pc", bus.io_out_pc, 64'h5550);
        chk("dexc.rpc", bus.io_out_redirect_pc, 64'h8000);

        // Reset in the middle of a drain aborts silently.
        do_reset();
        bus.io_in_csr_mstatus = 64'h8; bus.io_in_csr_mie = 64'h88; bus.io_in_msip = 1;
        bus.io_in_commit = 1; bus.io_in_commit_next_pc = 64'h900;
        @(negedge clock);
        chk("rdrain.drain_stall", bus.io_out_stall, 1);
        reset = 1'b1; bus.io_in_pipe_empty = 1; bus.io_in_commit = 0;
        @(negedge clock);
        reset = 1'b0;
        chk_zero("rdrain");

        do_reset();
        m_drain = 0; m_trap = 0; m_mret = 0; m_kind = 0; m_code = 0; m_pc = 0; m_npc = 0;
        bus.io_in_csr_mstatus = 64'h8; bus.io_in_csr_mie = 64'h88;
        bus.io_in_csr_mtvec = 64'h1001; bus.io_in_csr_mepc = 64'h7000;
        for (int c = 0; c < 3000; c++) begin
            rand_inputs();
            model_step();
            @(negedge clock);
            model_check();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
